// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use bubbles, EX redirects,
// I/D-memory busywait stalls, plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
   parameter int unsigned LU_BUBBLES = 1,
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned RA_W       = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [RA_W-1:0]  id_rs1,
   input  logic [RA_W-1:0]  id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [RA_W-1:0]  ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_write_en,
   input  logic             ex_redirect,
   input  logic             imem_busywait,
   input  logic             dmem_busywait,
   output logic             pc_en,
   output logic             pr1_en,
   output logic             pr1_flush,
   output logic             pr2_en,
   output logic             pr2_flush,
   output logic             pr3_en,
   output logic             pr4_en,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   typedef enum logic [1:0] {
      RUN,
      LU_STALL,
      REDIR_WAIT
   } state_t;

   state_t     state, state_nxt;
   logic [2:0] bub_cnt, bub_cnt_nxt;
   logic       hazard;
   logic       redirect_taken;

   assign hazard = ex_mem_read && ex_write_en && (ex_rd != '0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

   // NOTE: every output and next-state value gets a default first, so no path infers a latch.
   always_comb begin
      pc_en          = 1'b1;
      pr1_en         = 1'b1;
      pr1_flush      = 1'b0;
      pr2_en         = 1'b1;
      pr2_flush      = 1'b0;
      pr3_en         = 1'b1;
      pr4_en         = 1'b1;
      state_nxt      = state;
      bub_cnt_nxt    = bub_cnt;
      redirect_taken = 1'b0;

      if (reset) begin
         pc_en       = 1'b0;
         pr1_flush   = 1'b1;
         pr2_flush   = 1'b1;
         state_nxt   = RUN;
         bub_cnt_nxt = '0;
      end else if (dmem_busywait) begin
         // Whole pipe freezes; state and bubble count hold.
         pc_en  = 1'b0;
         pr1_en = 1'b0;
         pr2_en = 1'b0;
         pr3_en = 1'b0;
         pr4_en = 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (ex_redirect) begin
                  // ID holds a wrong-path instruction, so a coincident hazard is moot.
                  pr1_flush      = 1'b1;
                  pr2_flush      = 1'b1;
                  redirect_taken = 1'b1;
                  if (imem_busywait) state_nxt = REDIR_WAIT;
               end else if (hazard) begin
                  pc_en     = 1'b0;
                  pr1_en    = 1'b0;
                  pr2_flush = 1'b1;
                  if (LU_BUBBLES > 1) begin
                     state_nxt   = LU_STALL;
                     bub_cnt_nxt = 3'(LU_BUBBLES - 1);
                  end
               end else if (imem_busywait) begin
                  pc_en     = 1'b0;
                  pr1_flush = 1'b1;
               end
            end
            LU_STALL: begin
               pc_en     = 1'b0;
               pr1_en    = 1'b0;
               pr2_flush = 1'b1;
               if (bub_cnt == 3'd1) begin
                  state_nxt   = RUN;
                  bub_cnt_nxt = '0;
               end else begin
                  bub_cnt_nxt = bub_cnt - 3'd1;
               end
            end
            REDIR_WAIT: begin
               if (imem_busywait) begin
                  pc_en     = 1'b0;
                  pr1_flush = 1'b1;
                  pr2_flush = 1'b1;
               end else begin
                  state_nxt = RUN;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= RUN;
         bub_cnt <= '0;
      end else begin
         state   <= state_nxt;
         bub_cnt <= bub_cnt_nxt;
      end
   end

   // Counters saturate rather than wrap.
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (!pc_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
         if (redirect_taken && (flush_events != '1)) flush_events <= flush_events + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: two instances (LU_BUBBLES=3/CNT_W=32 and
// LU_BUBBLES=1/CNT_W=4) share stimulus; control outputs are checked as a packed vector.
module tb_pipeline_hazard_ctrl;

   // {pc_en, pr1_en, pr1_flush, pr2_en, pr2_flush, pr3_en, pr4_en}
   localparam logic [6:0] C_RUN   = 7'b1101011;
   localparam logic [6:0] C_RESET = 7'b0111111;
   localparam logic [6:0] C_HAZ   = 7'b0001111;
   localparam logic [6:0] C_REDIR = 7'b1111111;
   localparam logic [6:0] C_IMEM  = 7'b0111011;
   localparam logic [6:0] C_RWAIT = 7'b0111111;
   localparam logic [6:0] C_DMEM  = 7'b0000000;

   logic       clock;
   logic       reset;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_write_en, ex_redirect;
   logic       imem_busywait, dmem_busywait;

   logic        a_pc_en, a_pr1_en, a_pr1_flush, a_pr2_en, a_pr2_flush, a_pr3_en, a_pr4_en;
   logic [31:0] a_stall, a_flush;
   logic        b_pc_en, b_pr1_en, b_pr1_flush, b_pr2_en, b_pr2_flush, b_pr3_en, b_pr4_en;
   logic [3:0]  b_stall, b_flush;
   logic [6:0]  a_ctl, b_ctl;

   int n_tests = 0;
   int n_fail  = 0;

   assign a_ctl = {a_pc_en, a_pr1_en, a_pr1_flush, a_pr2_en, a_pr2_flush, a_pr3_en, a_pr4_en};
   assign b_ctl = {b_pc_en, b_pr1_en, b_pr1_flush, b_pr2_en, b_pr2_flush, b_pr3_en, b_pr4_en};

   pipeline_hazard_ctrl #(.LU_BUBBLES(3), .CNT_W(32), .RA_W(5)) u_dut_a (
      .clock(clock), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_write_en(ex_write_en),
      .ex_redirect(ex_redirect), .imem_busywait(imem_busywait), .dmem_busywait(dmem_busywait),
      .pc_en(a_pc_en), .pr1_en(a_pr1_en), .pr1_flush(a_pr1_flush),
      .pr2_en(a_pr2_en), .pr2_flush(a_pr2_flush), .pr3_en(a_pr3_en), .pr4_en(a_pr4_en),
      .stall_cycles(a_stall), .flush_events(a_flush)
   );

   pipeline_hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(4), .RA_W(5)) u_dut_b (
      .clock(clock), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_write_en(ex_write_en),
      .ex_redirect(ex_redirect), .imem_busywait(imem_busywait), .dmem_busywait(dmem_busywait),
      .pc_en(b_pc_en), .pr1_en(b_pr1_en), .pr1_flush(b_pr1_flush),
      .pr2_en(b_pr2_en), .pr2_flush(b_pr2_flush), .pr3_en(b_pr3_en), .pr4_en(b_pr4_en),
      .stall_cycles(b_stall), .flush_events(b_flush)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change just after the falling edge; checks follow 1 time unit later.
   task automatic next_cycle();
      @(negedge clock);
   endtask

   task automatic clear_inputs();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_mem_read = 1'b0; ex_write_en = 1'b0; ex_redirect = 1'b0;
      imem_busywait = 1'b0; dmem_busywait = 1'b0;
   endtask

   // lw x5 in EX; ID reads x3 (rs1) and x5 (rs2).
   task automatic set_load_use();
      ex_mem_read = 1'b1; ex_write_en = 1'b1; ex_rd = 5'd5;
      id_rs1 = 5'd3; id_use_rs1 = 1'b1;
      id_rs2 = 5'd5; id_use_rs2 = 1'b1;
   endtask

   task automatic do_reset();
      next_cycle();
      reset = 1'b1;
      clear_inputs();
      next_cycle();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();

      // Reset state
      next_cycle();
      #1;
      check("rst_ctl_a", 32'(a_ctl), 32'(C_RESET));
      check("rst_ctl_b", 32'(b_ctl), 32'(C_RESET));
      check("rst_stall_a", a_stall, 32'd0);
      check("rst_flush_a", a_flush, 32'd0);
      next_cycle();
      reset = 1'b0;
      #1;
      check("run_idle_a", 32'(a_ctl), 32'(C_RUN));

      // Load-use: one bubble (b) vs three bubbles (a)
      next_cycle();
      set_load_use();
      #1;
      check("lu_hit_b", 32'(b_ctl), 32'(C_HAZ));
      check("lu_hit_a", 32'(a_ctl), 32'(C_HAZ));
      next_cycle();
      clear_inputs();
      #1;
      check("lu1_done_b", 32'(b_ctl), 32'(C_RUN));
      check("lu3_bub2_a", 32'(a_ctl), 32'(C_HAZ));
      next_cycle();
      #1;
      check("lu3_bub3_a", 32'(a_ctl), 32'(C_HAZ));
      next_cycle();
      #1;
      check("lu3_done_a", 32'(a_ctl), 32'(C_RUN));
      check("lu3_stall_a", a_stall, 32'd3);
      check("lu1_stall_b", 32'(b_stall), 32'd1);

      // Near-misses: no hazard
      set_load_use(); ex_rd = 5'd0; id_rs2 = 5'd0;
      #1;
      check("nohaz_x0_b", 32'(b_ctl), 32'(C_RUN));
      next_cycle();
      set_load_use(); id_use_rs2 = 1'b0;
      #1;
      check("nohaz_nouse_b", 32'(b_ctl), 32'(C_RUN));
      next_cycle();
      set_load_use(); ex_write_en = 1'b0;
      #1;
      check("nohaz_nowr_b", 32'(b_ctl), 32'(C_RUN));
      next_cycle();
      set_load_use(); ex_mem_read = 1'b0;
      #1;
      check("nohaz_noload_a", 32'(a_ctl), 32'(C_RUN));
      next_cycle();
      set_load_use(); id_rs1 = 5'd5; id_rs2 = 5'd9;
      #1;
      check("haz_rs1_b", 32'(b_ctl), 32'(C_HAZ));

      // Redirect with instruction memory ready
      do_reset();
      ex_redirect = 1'b1;
      #1;
      check("redir_ctl_a", 32'(a_ctl), 32'(C_REDIR));
      next_cycle();
      clear_inputs();
      #1;
      check("redir_back_a", 32'(a_ctl), 32'(C_RUN));
      check("redir_cnt_a", a_flush, 32'd1);
      check("redir_cnt_b", 32'(b_flush), 32'd1);
      // Redirect and load-use together: redirect wins, no bubble
      set_load_use(); ex_redirect = 1'b1;
      #1;
      check("redir_haz_a", 32'(a_ctl), 32'(C_REDIR));
      next_cycle();
      clear_inputs();
      #1;
      check("redir_haz_run_a", 32'(a_ctl), 32'(C_RUN));
      check("redir_haz_cnt_a", a_flush, 32'd2);
      check("redir_haz_stall_a", a_stall, 32'd0);

      // Redirect while the fetch is busy for 4 more cycles
      do_reset();
      ex_redirect = 1'b1; imem_busywait = 1'b1;
      #1;
      check("rw_enter_a", 32'(a_ctl), 32'(C_REDIR));
      next_cycle();
      ex_redirect = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("rw_busy_a", 32'(a_ctl), 32'(C_RWAIT));
         next_cycle();
      end
      imem_busywait = 1'b0;
      #1;
      check("rw_release_a", 32'(a_ctl), 32'(C_RUN));
      check("rw_stall_a", a_stall, 32'd4);
      next_cycle();
      imem_busywait = 1'b1;
      #1;
      check("rw_to_run_a", 32'(a_ctl), 32'(C_IMEM));
      check("rw_flush_b", 32'(b_flush), 32'd1);

      // Data-memory stall in the middle of a load-use stall
      do_reset();
      set_load_use();
      #1;
      check("dm_haz_a", 32'(a_ctl), 32'(C_HAZ));
      next_cycle();
      clear_inputs();
      dmem_busywait = 1'b1;
      #1;
      check("dm_freeze_a", 32'(a_ctl), 32'(C_DMEM));
      check("dm_freeze_b", 32'(b_ctl), 32'(C_DMEM));
      next_cycle();
      ex_redirect = 1'b1;
      #1;
      check("dm_over_redir_b", 32'(b_ctl), 32'(C_DMEM));
      next_cycle();
      ex_redirect = 1'b0;
      #1;
      check("dm_freeze3_a", 32'(a_ctl), 32'(C_DMEM));
      next_cycle();
      dmem_busywait = 1'b0;
      #1;
      check("dm_resume2_a", 32'(a_ctl), 32'(C_HAZ));
      next_cycle();
      #1;
      check("dm_resume3_a", 32'(a_ctl), 32'(C_HAZ));
      next_cycle();
      #1;
      check("dm_done_a", 32'(a_ctl), 32'(C_RUN));
      check("dm_stall_a", a_stall, 32'd6);
      check("dm_stall_b", 32'(b_stall), 32'd4);
      check("dm_flush_b", 32'(b_flush), 32'd0);

      // Reset while in REDIR_WAIT, then counter saturation
      do_reset();
      ex_redirect = 1'b1; imem_busywait = 1'b1;
      next_cycle();
      ex_redirect = 1'b0;
      #1;
      check("rr_wait_a", 32'(a_ctl), 32'(C_RWAIT));
      next_cycle();
      reset = 1'b1;
      #1;
      check("rr_reset_a", 32'(a_ctl), 32'(C_RESET));
      next_cycle();
      reset = 1'b0;
      #1;
      check("rr_run_a", 32'(a_ctl), 32'(C_IMEM));
      check("rr_stall_a", a_stall, 32'd0);
      check("rr_flush_a", a_flush, 32'd0);
      repeat (20) next_cycle();
      imem_busywait = 1'b0;
      #1;
      check("sat_stall_a", a_stall, 32'd20);
      check("sat_stall_b", 32'(b_stall), 32'd15);
      ex_redirect = 1'b1;
      repeat (17) next_cycle();
      ex_redirect = 1'b0;
      #1;
      check("sat_flush_a", a_flush, 32'd17);
      check("sat_flush_b", 32'(b_flush), 32'd15);
      check("sat_hold_b", 32'(b_stall), 32'd15);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
